// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment-pattern table and segment bit positions for the seven-segment scanner
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_nib);
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment scanner with frame-synchronous update, blanking, LZ suppression and PWM dimming
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ACC_WIDTH    = 20,
  parameter int STEP         = 30,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [3:0]              bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_blank;
  logic [3:0]              r_pwm;
  logic                    r_pend_flag;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [ACC_WIDTH:0]      w_sum;
  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [IW-1:0]           w_hi;
  logic                    w_supp;
  logic                    w_on;
  assign w_sum  = {1'b0, r_acc} + (ACC_WIDTH + 1)'(STEP);
  assign w_tick = w_sum[ACC_WIDTH];
  assign w_wrap = w_tick && (r_idx == LAST);
  assign w_nib  = r_shadow[{r_idx, 2'b00} +: 4];
  seg7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );
  // highest nonzero nibble; digit 0 counts as the floor so an all-zero value still shows "0"
  always_comb begin
    w_hi = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (r_shadow[4*i +: 4] != 4'd0) w_hi = IW'(i);
  end
  assign w_supp = lz_en && (r_idx > w_hi);
  assign w_on   = (r_blank == '0) && (r_pwm <= bright) && !w_supp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_blank <= '0;
      r_pwm   <= '0;
      frame   <= 1'b0;
    end else begin
      r_acc   <= w_sum[ACC_WIDTH-1:0];
      r_idx   <= w_tick ? ((r_idx == LAST) ? '0 : r_idx + IW'(1)) : r_idx;
      r_blank <= w_tick ? BW'(BLANK_CYCLES) : r_blank - BW'(r_blank != '0);
      r_pwm   <= r_pwm + 4'd1;
      frame   <= w_wrap;
    end
  end
  // a load on the wrapping tick is kept pending: the commit uses the value captured earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_flag <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
    end else begin
      if (w_wrap && r_pend_flag) begin
        r_shadow    <= r_pend_data;
        r_shadow_dp <= r_pend_dp;
      end
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_in;
      end
      r_pend_flag <= load || (r_pend_flag && !w_wrap);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= '0;
      dp    <= 1'b0;
      dig_n <= '1;
    end else begin
      seg   <= w_supp ? 7'd0 : w_seg;
      dp    <= !w_supp && r_shadow_dp[r_idx];
      dig_n <= w_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized self-checking bench against a cycle-count based display model
module tb_seg7_scan;
  localparam int ND = 4, AW = 4, STEP = 4, BLANK = 1;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0] dp_in = '0;
  logic load = 1'b0, lz_en = 1'b0;
  logic [3:0] bright = 4'd15;
  logic [6:0] seg;
  logic dp, frame;
  logic [3:0] dig_n;
  seg7_scan #(.NUM_DIGITS(ND), .ACC_WIDTH(AW), .STEP(STEP), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .bright(bright), .seg(seg), .dp(dp), .dig_n(dig_n), .frame(frame)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int n;
  logic [15:0] m_pend, m_shadow;
  logic [3:0] m_pdp, m_sdp;
  bit m_pflag;
  logic [6:0] e_seg;
  logic e_dp, e_frame, e_chk;
  logic [3:0] e_dign;
  logic [6:0] last_seg [4];
  logic last_dp [4];
  int en_cnt [4];
  function automatic int ticks(int k);
    return (k * STEP) >> AW;
  endfunction
  function automatic bit is_tick(int k);
    return k > 0 && ticks(k) != ticks(k - 1);
  endfunction
  task automatic model_reset();
    n = 0; m_pend = '0; m_shadow = '0; m_pdp = '0; m_sdp = '0; m_pflag = 0;
  endtask
  // advance one clock: expectations derive from the model state before the edge
  task automatic step();
    int idx, hi;
    bit blanking, supp, on;
    idx = ticks(n) % ND;
    blanking = 0;
    for (int j = 0; j < BLANK; j++) if (n - j >= 1 && is_tick(n - j)) blanking = 1;
    hi = 0;
    for (int i = 1; i < ND; i++) if (m_shadow[4*i +: 4] != 0) hi = i;
    supp = lz_en && idx > hi;
    on = !blanking && (n % 16) <= int'(bright) && !supp;
    for (int i = 0; i < ND; i++) e_dign[i] = !(on && i == idx);
    e_seg = supp ? 7'd0 : HEX[m_shadow[4*idx +: 4]];
    e_dp = !supp && m_sdp[idx];
    e_chk = on || supp;
    n++;
    e_frame = is_tick(n) && ticks(n) % ND == 0;
    if (e_frame && m_pflag) begin m_shadow = m_pend; m_sdp = m_pdp; m_pflag = 0; end
    if (load) begin m_pend = data; m_pdp = dp_in; m_pflag = 1; end
    @(posedge clk); #1;
    for (int i = 0; i < ND; i++) if (!dig_n[i]) begin en_cnt[i]++; last_seg[i] = seg; last_dp[i] = dp; end
  endtask
  task automatic clear_stats();
    for (int i = 0; i < ND; i++) begin en_cnt[i] = 0; last_seg[i] = 'x; last_dp[i] = 1'bx; end
  endtask
  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    data = d; dp_in = p; load = 1'b1;
  endtask
  task automatic test_reset();
    checks++; if (dig_n !== 4'hF) begin failures++; $display("FAIL reset_dig_n got=%b exp=1111", dig_n); end
    checks++; if (seg !== 7'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
    checks++; if ({dp, frame} !== 2'b00) begin failures++; $display("FAIL reset_dp_frame got=%b exp=00", {dp, frame}); end
    rst = 1'b0; model_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (dig_n !== e_dign) begin failures++; $display("FAIL reset_release dig_n n=%0d got=%b exp=%b", n, dig_n, e_dign); end
    end
  endtask
  task automatic test_scan();
    int frames = 0;
    for (int c = 0; c < 44; c++) begin
      step();
      frames += int'(frame);
      checks++; if (dig_n !== e_dign || frame !== e_frame) begin failures++; $display("FAIL scan n=%0d dig_n/frame got=%b/%b exp=%b/%b", n, dig_n, frame, e_dign, e_frame); end
      if (e_chk) begin checks++; if ({seg, dp} !== {e_seg, e_dp}) begin failures++; $display("FAIL scan_seg n=%0d got=%h/%b exp=%h/%b", n, seg, dp, e_seg, e_dp); end end
    end
    checks++; if (frames < 2 || frames > 3) begin failures++; $display("FAIL scan_frame_count got=%0d exp=2..3", frames); end
  endtask
  task automatic test_load();
    logic [6:0] want [4];
    want = '{7'h71, 7'h77, 7'h5B, 7'h06};
    repeat (2) step();
    pulse_load(16'h12AF, 4'b0100);
    step(); load = 1'b0;
    clear_stats();
    for (int c = 0; c < 48; c++) begin
      step();
      checks++; if (dig_n !== e_dign || frame !== e_frame) begin failures++; $display("FAIL load n=%0d dig_n/frame got=%b/%b exp=%b/%b", n, dig_n, frame, e_dign, e_frame); end
      if (e_chk) begin checks++; if ({seg, dp} !== {e_seg, e_dp}) begin failures++; $display("FAIL load_seg n=%0d got=%h/%b exp=%h/%b", n, seg, dp, e_seg, e_dp); end end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (last_seg[i] !== want[i] || last_dp[i] !== (i == 2)) begin failures++; $display("FAIL load_digit%0d got=%h/%b exp=%h/%b", i, last_seg[i], last_dp[i], want[i], i == 2); end
    end
  endtask
  task automatic test_lz();
    lz_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_load(pass == 0 ? 16'h0050 : 16'h0000, 4'b0000);
      step(); load = 1'b0;
      repeat (20) step();
      clear_stats();
      for (int c = 0; c < 32; c++) begin
        step();
        checks++; if (dig_n !== e_dign) begin failures++; $display("FAIL lz n=%0d dig_n got=%b exp=%b", n, dig_n, e_dign); end
        if (e_chk) begin checks++; if ({seg, dp} !== {e_seg, e_dp}) begin failures++; $display("FAIL lz_seg n=%0d got=%h/%b exp=%h/%b", n, seg, dp, e_seg, e_dp); end end
      end
      checks++; if (en_cnt[3] != 0 || en_cnt[2] != 0) begin failures++; $display("FAIL lz_upper_enabled pass=%0d got=%0d,%0d exp=0,0", pass, en_cnt[3], en_cnt[2]); end
      checks++; if (last_seg[0] !== 7'h3F) begin failures++; $display("FAIL lz_digit0 pass=%0d got=%h exp=3F", pass, last_seg[0]); end
      if (pass == 0) begin checks++; if (last_seg[1] !== 7'h6D) begin failures++; $display("FAIL lz_digit1 got=%h exp=6D", last_seg[1]); end end
      else begin checks++; if (en_cnt[1] != 0) begin failures++; $display("FAIL lz_zero_digit1 got=%0d exp=0", en_cnt[1]); end end
    end
    lz_en = 1'b0;
  endtask
  task automatic test_bright();
    for (int pass = 0; pass < 2; pass++) begin
      bright = pass == 0 ? 4'd3 : 4'd0;
      for (int c = 0; c < 64; c++) begin
        step();
        checks++; if (dig_n !== e_dign) begin failures++; $display("FAIL bright=%0d n=%0d dig_n got=%b exp=%b", bright, n, dig_n, e_dign); end
      end
    end
    bright = 4'd15;
  endtask
  task automatic test_reset_mid();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; model_reset();
    repeat (2) step();
    pulse_load(16'h1111, 4'b0001); step(); load = 1'b0;
    repeat (2) step();
    pulse_load(16'h2222, 4'b0010); step(); load = 1'b0;
    repeat (4) step();
    rst = 1'b1; #1;
    checks++; if (dig_n !== 4'hF || seg !== 7'h00) begin failures++; $display("FAIL async_reset got=%b/%h exp=1111/00", dig_n, seg); end
    @(posedge clk); #1; rst = 1'b0; model_reset();
    clear_stats();
    for (int c = 0; c < 50; c++) begin
      if (c == 20) pulse_load(16'h3333, 4'b0000);
      step(); load = 1'b0;
      if (c == 19) begin
        checks++; if (last_seg[0] !== 7'h3F || last_seg[3] !== 7'h3F) begin failures++; $display("FAIL reset_discard got=%h,%h exp=3F,3F", last_seg[0], last_seg[3]); end
      end
      checks++; if (dig_n !== e_dign || frame !== e_frame) begin failures++; $display("FAIL reset_mid n=%0d dig_n/frame got=%b/%b exp=%b/%b", n, dig_n, frame, e_dign, e_frame); end
      if (e_chk) begin checks++; if ({seg, dp} !== {e_seg, e_dp}) begin failures++; $display("FAIL reset_mid_seg n=%0d got=%h/%b exp=%h/%b", n, seg, dp, e_seg, e_dp); end end
    end
    checks++; if (last_seg[0] !== 7'h4F || last_seg[3] !== 7'h4F) begin failures++; $display("FAIL commit_3333 got=%h,%h exp=4F,4F", last_seg[0], last_seg[3]); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      load = ($urandom_range(0, 7) == 0);
      data = 16'($urandom); dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      step();
      checks++; if (dig_n !== e_dign || frame !== e_frame) begin failures++; $display("FAIL random n=%0d dig_n/frame got=%b/%b exp=%b/%b", n, dig_n, frame, e_dign, e_frame); end
      if (e_chk) begin checks++; if ({seg, dp} !== {e_seg, e_dp}) begin failures++; $display("FAIL random_seg n=%0d got=%h/%b exp=%h/%b", n, seg, dp, e_seg, e_dp); end end
    end
    load = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_bright();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
